// File: rtl/multi_edge_pulse.sv
// Multi-channel edge detector: per-channel synchronizer, debouncer and
// retriggerable pulse stretcher, plus a shared count of qualifying edges.
module multi_edge_pulse #(
   parameter int unsigned N_CH        = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DEB_LEN     = 4,
   parameter int unsigned PULSE_LEN   = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] in_trig,
   input  logic [1:0]      edge_mode,
   output logic [N_CH-1:0] out_pulse,
   output logic [N_CH-1:0] level_db,
   output logic            any_pulse,
   output logic [7:0]      evt_cnt
);

   // Debounce counter only ever needs to hold DEB_LEN-1.
   localparam int unsigned DW        = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
   localparam logic [DW-1:0] DebMax  = DW'(DEB_LEN - 1);
   localparam logic [7:0]   PulseLoad = 8'(PULSE_LEN);

   localparam logic [1:0] ModeRise = 2'b00;
   localparam logic [1:0] ModeFall = 2'b01;
   localparam logic [1:0] ModeBoth = 2'b10;

   logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
   logic [N_CH-1:0]                  sync;
   logic [N_CH-1:0][DW-1:0]          deb_q, deb_d;
   logic [N_CH-1:0]                  level_q, level_d;
   logic [N_CH-1:0][7:0]             pcnt_q, pcnt_d;
   logic [N_CH-1:0]                  qual, qual_q;
   logic [N_CH-1:0]                  out_q;
   logic                             any_q;
   logic [7:0]                       evt_q, evt_d;

   assign sync = sync_q[SYNC_STAGES-1];

   // Synchronizer chain: stage 0 samples the raw asynchronous inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], in_trig};
      end
   end

   // Debounce, edge qualification and pulse counter next-state per channel.
   always_comb begin
      deb_d   = '0;
      level_d = level_q;
      qual    = '0;
      pcnt_d  = '0;
      for (int ch = 0; ch < int'(N_CH); ch++) begin
         pcnt_d[ch] = (pcnt_q[ch] != 8'd0) ? pcnt_q[ch] - 8'd1 : 8'd0;
         if (sync[ch] != level_q[ch]) begin
            if (deb_q[ch] == DebMax) begin
               level_d[ch] = sync[ch];
               qual[ch]    = (edge_mode == ModeBoth) ||
                             ((edge_mode == ModeRise) && sync[ch]) ||
                             ((edge_mode == ModeFall) && !sync[ch]);
            end else begin
               deb_d[ch] = deb_q[ch] + DW'(1);
            end
         end
         // A new qualifying edge reloads the counter, extending any active pulse.
         if (qual[ch]) begin
            pcnt_d[ch] = PulseLoad;
         end
      end
   end

   // Event counter adds the edges qualified in the previous cycle so it
   // moves in the same cycle the corresponding pulses appear.
   always_comb begin
      evt_d = evt_q;
      for (int ch = 0; ch < int'(N_CH); ch++) begin
         evt_d = evt_d + 8'(qual_q[ch]);
      end
   end

   // Channel state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_q   <= '0;
         level_q <= '0;
         pcnt_q  <= '0;
         qual_q  <= '0;
         out_q   <= '0;
         any_q   <= 1'b0;
         evt_q   <= 8'd0;
      end else begin
         deb_q   <= deb_d;
         level_q <= level_d;
         pcnt_q  <= pcnt_d;
         qual_q  <= qual;
         for (int ch = 0; ch < int'(N_CH); ch++) begin
            out_q[ch] <= (pcnt_q[ch] != 8'd0);
         end
         any_q   <= (pcnt_q != '0);
         evt_q   <= evt_d;
      end
   end

   assign out_pulse = out_q;
   assign level_db  = level_q;
   assign any_pulse = any_q;
   assign evt_cnt   = evt_q;

endmodule
